// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared constants for the data-memory arbiter:
//   - FSM state encodings (plain localparams, legacy-compatible encoding)
//   - requester port identifiers
//   - number of byte beats per 32-bit word
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int         NUM_BEATS = 4;
  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter holding the "last served" pointer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_cpu/req_dbg : requests from port 0 / port 1
//   upd, upd_port   : when upd is high, record upd_port as last served
//   gnt_vld         : at least one request present
//   gnt_port        : winning port id (valid with gnt_vld)
// After reset the pointer says DBG was last, so the CPU wins the first tie.
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_cpu,
  input  logic req_dbg,
  input  logic upd,
  input  logic upd_port,
  output logic gnt_vld,
  output logic gnt_port
);

  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBG;
    end else if (upd) begin
      last_q <= upd_port;
    end
  end

  // On a tie the port that was not served last wins; a lone request always wins.
  assign gnt_vld  = req_cpu | req_dbg;
  assign gnt_port = (req_cpu & req_dbg) ? ~last_q : req_dbg;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one byte-wide synchronous data memory between the CPU MEM stage
// (port 0) and a debug/loader port (port 1). Each 32-bit word request is
// split into four little-endian byte beats.
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   cpu_* / dbg_*           : word request ports (req, we, addr, wdata in;
//                             ack pulse, rdata out); requesters hold until ack
//   cpu_stall_o             : CPU request outstanding and not yet acked
//   err_o                   : pulses with ack of a misaligned request
//   mem_en_o .. mem_wdata_o : byte memory beat interface
//   mem_rdata_i             : read byte, valid the cycle after mem_en_o
//   stall_cnt_o             : saturating count of CPU stall cycles
// Timing: request sampled at edge N, beats N+1..N+4, capture N+5, ack N+6.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [31:0]       stall_cnt_o
);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [1:0]        state_q;
  logic [1:0]        beat_q;
  logic              port_q;
  logic              we_q;
  logic              err_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       stall_cnt_q;

  logic              gnt_vld;
  logic              gnt_port;
  logic              sel_we;
  logic [MEM_AW-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              misaligned;
  logic              in_xfer;
  logic              in_capt;
  logic              in_done;
  logic              rd_ok;
  logic              unused_addr_hi;

  rr_arb2 u_arb (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .req_cpu  (cpu_req_i),
    .req_dbg  (dbg_req_i),
    .upd      (in_done),
    .upd_port (port_q),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  // Address bits above the memory depth select nothing; the memory simply wraps.
  assign unused_addr_hi = ^{cpu_addr_i[ADDR_W-1:MEM_AW], dbg_addr_i[ADDR_W-1:MEM_AW]};

  assign sel_we     = (gnt_port == PORT_DBG) ? dbg_we_i : cpu_we_i;
  assign sel_addr   = (gnt_port == PORT_DBG) ? dbg_addr_i[MEM_AW-1:0] : cpu_addr_i[MEM_AW-1:0];
  assign sel_wdata  = (gnt_port == PORT_DBG) ? dbg_wdata_i : cpu_wdata_i;
  assign misaligned = |sel_addr[1:0];

  assign in_xfer = (state_q == ST_XFER);
  assign in_capt = (state_q == ST_CAPT);
  assign in_done = (state_q == ST_DONE);

  // Grant / beat sequencing
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      port_q  <= PORT_CPU;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            port_q <= gnt_port;
            we_q   <= sel_we;
            beat_q <= 2'd0;
            err_q  <= misaligned;
            // A misaligned request never touches memory; it only reports err.
            state_q <= misaligned ? ST_DONE : ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= ST_CAPT;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        ST_CAPT: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request payload latch and read-byte assembly (data path, no reset needed;
  // outputs are gated by state so stale contents are never visible)
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_IDLE) && gnt_vld) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
    // Memory returns each byte one cycle after its beat, so the byte landing
    // now belongs to the previous beat; the last one lands during CAPT.
    if (!we_q) begin
      if (in_xfer && (beat_q != 2'd0)) begin
        rdata_q[{beat_q - 2'd1, 3'b000} +: 8] <= mem_rdata_i;
      end else if (in_capt) begin
        rdata_q[31:24] <= mem_rdata_i;
      end
    end
  end

  // Stall counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'd0;
    end else if (cpu_stall_o) begin
      stall_cnt_q <= sat_inc32(stall_cnt_q);
    end
  end

  assign mem_en_o    = in_xfer;
  assign mem_we_o    = in_xfer & we_q;
  assign mem_addr_o  = in_xfer ? (addr_q + MEM_AW'(beat_q)) : '0;
  assign mem_wdata_o = in_xfer ? wdata_q[{beat_q, 3'b000} +: 8] : 8'd0;

  assign rd_ok       = in_done & ~we_q & ~err_q;
  assign cpu_ack_o   = in_done & (port_q == PORT_CPU);
  assign dbg_ack_o   = in_done & (port_q == PORT_DBG);
  assign cpu_rdata_o = (rd_ok && (port_q == PORT_CPU)) ? rdata_q : 32'd0;
  assign dbg_rdata_o = (rd_ok && (port_q == PORT_DBG)) ? rdata_q : 32'd0;
  assign err_o       = in_done & err_q;

  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  assign stall_cnt_o = stall_cnt_q;

endmodule
